// File: rtl/ic1337_driver.sv
// ---------------------------------------------------------------------------
// ic1337_driver
//
// Steering controller for the ic1337 two-flop chip. It takes a requested
// output state {Q1,Q0} and emits a sequence of {I2,I1,I0} codes that move
// the chip to that state. It keeps a shadow copy of the chip state and, once
// the target is reached, parks the chip with a code that holds it there.
//
// Optional build macro:
//   IC1337_FBCHK_EN  - compare the chip's Q feedback against the shadow
//                      while idle or steering. A mismatch resyncs the
//                      shadow. Too many resyncs for one request lock the
//                      block in ERR until reset.
//                      When the macro is not defined, q_fb is not used and
//                      err is held at 0.
//
// Parameters:
//   RETRY_MAX - number of feedback resyncs allowed per request before ERR
//   RESET_Q   - shadow {Q1,Q0} after reset (the chip's power-up state)
//
// Ports:
//   clk     in   1  rising-edge clock, shared with ic1337
//   rst_n   in   1  asynchronous active-low reset
//   req     in   1  request strobe, accepted when req=1 and ready=1
//   target  in   2  requested {Q1,Q0}, sampled on acceptance
//   q_fb    in   2  chip {Q1,Q0} feedback
//   i_drv   out  3  registered {I2,I1,I0} driven to the chip
//   ready   out  1  a request can be accepted
//   done    out  1  one-cycle pulse when the shadow reaches the target
//   err     out  1  sticky feedback-failure flag
//
// States:
//   HOLD  | chip parked on the shadow state; requests accepted
//   STEER | driving steer codes toward the latched target
//   ERR   | feedback check gave up; park on q_fb until reset
// ---------------------------------------------------------------------------
module ic1337_driver #(
    parameter int         RETRY_MAX = 1,
    parameter logic [1:0] RESET_Q   = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [1:0] target,
    input  logic [1:0] q_fb,
    output logic [2:0] i_drv,
    output logic       ready,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_STEER = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    // Next {Q1,Q0} of the chip for a given present state and input code.
    function automatic logic [1:0] chip_next(input logic [1:0] q, input logic [2:0] code);
        logic [1:0] r;
        r = q;
        if (code[2]) begin
            if (code[0]) r = {q[1], 1'b1};
            else         r = 2'b11;
        end else begin
            case (code[1:0])
                2'b10:        r = 2'b00;
                2'b00, 2'b11: r = {~q[1], q[0]};
                default:      r = {1'b0, q[0]};
            endcase
        end
        return r;
    endfunction

    // Code that holds the chip in its current state. State 10 has no hold
    // code: 000 lets it decay to 00, which then parks normally.
    function automatic logic [2:0] park_code(input logic [1:0] q);
        logic [2:0] r;
        case (q)
            2'b00:   r = 3'b001;
            2'b01:   r = 3'b101;
            2'b11:   r = 3'b101;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // One step toward the target. Every path is at most two steps long.
    function automatic logic [2:0] steer_code(input logic [1:0] s, input logic [1:0] t);
        logic [2:0] r;
        case (t)
            2'b00:   r = 3'b010;
            2'b11:   r = 3'b100;
            2'b01:   r = s[0] ? 3'b001 : 3'b100;
            default: r = (s == 2'b00) ? 3'b000 : 3'b010;
        endcase
        return r;
    endfunction

    state_t     state, state_nxt;
    logic [1:0] shadow, shadow_nxt;
    logic [1:0] tgt, tgt_nxt;
    logic [2:0] i_drv_nxt;
    logic       done_nxt;
    logic       accept;

    assign accept = (state == S_HOLD) && req;
    assign ready  = (state == S_HOLD);

`ifdef IC1337_FBCHK_EN
    localparam int RW = $clog2(RETRY_MAX + 2);

    logic [RW-1:0] retry, retry_nxt;
    logic          fb_mis;

    assign fb_mis = (state != S_ERR) && (q_fb != shadow);
    assign err    = (state == S_ERR);

    always_comb begin
        retry_nxt = retry;
        if (state != S_ERR) begin
            retry_nxt = (accept ? '0 : retry) + RW'(fb_mis);
        end
    end

    // On a mismatch the chip is trusted over the shadow.
    always_comb begin
        shadow_nxt = chip_next(shadow, i_drv);
        if (fb_mis) shadow_nxt = chip_next(q_fb, i_drv);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retry <= '0;
        else        retry <= retry_nxt;
    end
`else
    assign err = 1'b0;

    always_comb begin
        shadow_nxt = chip_next(shadow, i_drv);
    end
`endif

    always_comb begin
        state_nxt = state;
        i_drv_nxt = park_code(shadow_nxt);
        done_nxt  = 1'b0;
        tgt_nxt   = accept ? target : tgt;

        case (state)
            S_HOLD: begin
                if (accept) begin
                    if (shadow_nxt == target) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_STEER;
                        i_drv_nxt = steer_code(shadow_nxt, target);
                    end
                end
            end
            S_STEER: begin
                if (shadow_nxt == tgt) begin
                    state_nxt = S_HOLD;
                    done_nxt  = 1'b1;
                end else begin
                    i_drv_nxt = steer_code(shadow_nxt, tgt);
                end
            end
            S_ERR: begin
                i_drv_nxt = park_code(q_fb);
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase

`ifdef IC1337_FBCHK_EN
        if ((state != S_ERR) && (retry_nxt > RW'(RETRY_MAX))) begin
            state_nxt = S_ERR;
            done_nxt  = 1'b0;
            i_drv_nxt = park_code(q_fb);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_HOLD;
            shadow <= RESET_Q;
            tgt    <= 2'b00;
            i_drv  <= park_code(RESET_Q);
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            tgt    <= tgt_nxt;
            i_drv  <= i_drv_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: doc/ic1337_driver.md
Name: ic1337_driver

Overview:
Steering controller for the ic1337 two-flop chip. Converts a requested output state {Q1,Q0} into a sequence of {I2,I1,I0} input codes that drives the chip to that state. Keeps an internal shadow model of the chip, parks the chip once the target is reached, and optionally checks the chip's Q feedback. Sits on the input side of ic1337 and shares its clock.

Parameters:
RETRY_MAX, 1, number of feedback-mismatch resyncs allowed per request before entering ERR.
RESET_Q, 2'b00, shadow {Q1,Q0} value after reset; must equal the chip's power-up state.

Ports:
clk  input  1  rising-edge clock, shared with ic1337
rst_n  input  1  asynchronous, active-low reset
req  input  1  request strobe; accepted when req=1 and ready=1
target  input  2  requested {Q1,Q0}; sampled on acceptance
q_fb  input  2  chip {Q1,Q0} feedback
i_drv  output  3  registered {I2,I1,I0} driven to the chip
ready  output  1  request can be accepted
done  output  1  one-cycle pulse: shadow reached the latched target
err  output  1  sticky feedback-failure flag

Behaviour:
- Chip next-state model (code -> Q1Q0 effect):
  - 1x0: both set, giving 11.
  - 1x1: Q0=1, Q1 hold.
  - 010: both cleared, giving 00.
  - 000 and 011: Q0 hold, Q1 toggle.
  - 001: Q0 hold, Q1=0.
- Shadow update: on every edge outside reset, shadow <= model(shadow, i_drv). Shadow therefore equals the chip Q on the same edge.
- Park code, chosen by shadow:
  - 00 -> 001
  - 01 -> 101
  - 11 -> 101
  - 10 -> 000. State 10 has no hold code, so it decays to 00 one cycle later and then parks at 001.
- Steer code, chosen by (shadow, tgt):
  - tgt 00: 010
  - tgt 11: 100
  - tgt 01: 001 if Q0=1, else 100
  - tgt 10: 000 if shadow=00, else 010
  - Worst case is 2 steps.
- FSM states: HOLD, STEER, ERR.
  - Reset: state HOLD, shadow=RESET_Q, i_drv=park(RESET_Q), ready=1, done=0, err=0, retry count=0.
  - HOLD: ready=1 and i_drv=park(shadow_next).
    - On req, latch tgt and clear the retry count.
    - If shadow_next==tgt, stay in HOLD and drive done=1 on the next cycle (0-step case).
    - Otherwise go to STEER with i_drv=steer(shadow_next, tgt).
  - STEER: ready=0; req is ignored.
    - At each edge, if shadow_next==tgt, go to HOLD with done=1 for one cycle and i_drv=park.
    - Otherwise i_drv=steer(shadow_next, tgt).
  - Latency from accepting edge to done: 1 cycle (0 steps), 2 cycles (1 step), 3 cycles (2 steps).
  - done and ready are registered. ready rises in the same cycle that done pulses, so a back-to-back req is allowed.
  - ERR: ready=0, done=0, err=1, i_drv=park(q_fb). Exited only by rst_n.
- rst_n low mid-STEER: immediate return to reset values. The latched target is discarded.

Optional Feature:
IC1337_FBCHK_EN
- Defined:
  - At every edge in HOLD or STEER, compare q_fb against the shadow.
  - On mismatch, shadow <= model(q_fb, i_drv) and the retry count increments.
  - If the count exceeds RETRY_MAX, go to ERR.
  - STEER continues from the resynced shadow.
- Undefined: q_fb is ignored, err is tied to 0, and the ERR state is unreachable.

Test Plan:
1. Assert rst_n=0 mid-run -> i_drv=001, ready=1, done=0, err=0 immediately; after release the shadow is 00.
2. From 00, req target=11 -> i_drv=100 next cycle, then done=1 with i_drv=101; q_fb settles at 11.
3. From 11, req target=10 -> i_drv 010, then 000; done at accept+3; next cycle i_drv=000; chip reaches 00, then park 001.
4. From 01, req target=01 -> no steer code; done=1 one cycle after accept; i_drv stays 101.
5. IC1337_FBCHK_EN with RETRY_MAX=1: force q_fb=00 twice during a steer to 11 -> first mismatch resyncs and continues steering; second mismatch gives err=1, ready=0, held until rst_n.
6. In STEER toward 01 from 00, pulse req with target=00 -> ignored; completes at 01 with done at accept+3.
